vout_axi4s_to_video_core: RTL and testbench

Converts the AXI4-Stream frame produced by the VDMA read core into raster video for the DVI transmitter. It generates the h/v timing internally, locks the stream's frame start (tuser[0]) to the first active pixel, and outputs registered de/hsync/vsync/data. It sits directly downstream of the AXI4-to-AXI4-Stream VDMA core and directly upstream of the TMDS encoder.

---
 rtl/vout_axi4s_to_video_core_if.sv | 14 +
 rtl/vout_axi4s_to_video_core.sv | 199 +++++++++++++++++++
 tb/tb_vout_axi4s_to_video_core.sv | 191 +++++++++++++++++++
 3 files changed

// File: rtl/vout_axi4s_to_video_core_if.sv
// rtl/vout_axi4s_to_video_core_if.sv - AXI4-Stream pixel bundle between VDMA read core and video output
interface vout_axi4s_to_video_core_if #(
    parameter int USER_WIDTH = 2,
    parameter int DATA_WIDTH = 24
);
    logic [USER_WIDTH-1:0] tuser;
    logic                  tlast;
    logic [DATA_WIDTH-1:0] tdata;
    logic                  tvalid;
    logic                  tready;

    modport master (output tuser, output tlast, output tdata, output tvalid, input  tready);
    modport slave  (input  tuser, input  tlast, input  tdata, input  tvalid, output tready);
endinterface

// File: rtl/vout_axi4s_to_video_core.sv
// rtl/vout_axi4s_to_video_core.sv - AXI4-Stream to raster video with internal timing; option VOUT_AXI4S_TO_VIDEO_UNDERFLOW_CNT_EN
module vout_axi4s_to_video_core #(
    parameter int   AXI4S_USER_WIDTH = 2,
    parameter int   AXI4S_DATA_WIDTH = 24,
    parameter int   H_WIDTH          = 12,
    parameter int   V_WIDTH          = 12,
    parameter logic SYNC_POL         = 1'b0
) (
    input  logic                        aresetn,
    input  logic                        aclk,
    input  logic                        enable,
    output logic                        busy,
    input  logic [H_WIDTH-1:0]          param_htotal,
    input  logic [H_WIDTH-1:0]          param_hdisp,
    input  logic [H_WIDTH-1:0]          param_hsync_start,
    input  logic [H_WIDTH-1:0]          param_hsync_end,
    input  logic [V_WIDTH-1:0]          param_vtotal,
    input  logic [V_WIDTH-1:0]          param_vdisp,
    input  logic [V_WIDTH-1:0]          param_vsync_start,
    input  logic [V_WIDTH-1:0]          param_vsync_end,
    vout_axi4s_to_video_core_if.slave   s_axi4s,
    output logic                        out_vsync,
    output logic                        out_hsync,
    output logic                        out_de,
    output logic [AXI4S_DATA_WIDTH-1:0] out_data,
    output logic                        out_underflow
`ifdef VOUT_AXI4S_TO_VIDEO_UNDERFLOW_CNT_EN
    ,
    output logic [15:0]                 status_underflow_count
`endif
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SYNC = 2'd1,
        ST_RUN  = 2'd2
    } state_t;

    state_t             r_state;
    logic [H_WIDTH-1:0] r_h_cnt;
    logic [V_WIDTH-1:0] r_v_cnt;
    logic [H_WIDTH-1:0] r_htotal;
    logic [H_WIDTH-1:0] r_hdisp;
    logic [H_WIDTH-1:0] r_hsync_start;
    logic [H_WIDTH-1:0] r_hsync_end;
    logic [V_WIDTH-1:0] r_vtotal;
    logic [V_WIDTH-1:0] r_vdisp;
    logic [V_WIDTH-1:0] r_vsync_start;
    logic [V_WIDTH-1:0] r_vsync_end;
    logic               r_underflow;

    logic w_h_wrap;
    logic w_frame_end;
    logic w_de;
    logic w_hs_act;
    logic w_vs_act;
    logic w_hlast;
    logic w_sof_held;
    logic w_tready;
    logic w_fault;
    logic w_unused_tuser;

    // Frame boundary is the edge that wraps both counters back to (0,0)
    assign w_h_wrap    = (r_h_cnt == r_htotal);
    assign w_frame_end = w_h_wrap && (r_v_cnt == r_vtotal);
    assign w_de        = (r_h_cnt < r_hdisp) && (r_v_cnt < r_vdisp);
    assign w_hs_act    = (r_h_cnt >= r_hsync_start) && (r_h_cnt < r_hsync_end);
    assign w_vs_act    = (r_v_cnt >= r_vsync_start) && (r_v_cnt < r_vsync_end);
    assign w_hlast     = (r_h_cnt == (r_hdisp - H_WIDTH'(1)));
    assign w_sof_held  = s_axi4s.tvalid && s_axi4s.tuser[0];

    // tuser[1] (frame end) carries no information the timing generator needs
    assign w_unused_tuser = ^s_axi4s.tuser;

    // Ready never looks at tvalid: SYNC drains until a frame-start beat sits at the head
    always_comb begin
        w_tready = 1'b0;
        case (r_state)
            ST_SYNC: w_tready = ~s_axi4s.tuser[0];
            ST_RUN:  w_tready = w_de;
            default: w_tready = 1'b0;
        endcase
    end
    assign s_axi4s.tready = w_tready;

    // Missing pixel or a tlast that does not land on the last active pixel of the line
    assign w_fault = (r_state == ST_RUN) && w_de &&
                     (!s_axi4s.tvalid || (s_axi4s.tlast != w_hlast));

    // Timing FSM: counters, shadow parameters, lock state and per-frame underflow flag
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            r_state       <= ST_IDLE;
            r_h_cnt       <= '0;
            r_v_cnt       <= '0;
            r_htotal      <= '0;
            r_hdisp       <= '0;
            r_hsync_start <= '0;
            r_hsync_end   <= '0;
            r_vtotal      <= '0;
            r_vdisp       <= '0;
            r_vsync_start <= '0;
            r_vsync_end   <= '0;
            r_underflow   <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    r_h_cnt     <= '0;
                    r_v_cnt     <= '0;
                    r_underflow <= 1'b0;
                    if (enable) begin
                        r_htotal      <= param_htotal;
                        r_hdisp       <= param_hdisp;
                        r_hsync_start <= param_hsync_start;
                        r_hsync_end   <= param_hsync_end;
                        r_vtotal      <= param_vtotal;
                        r_vdisp       <= param_vdisp;
                        r_vsync_start <= param_vsync_start;
                        r_vsync_end   <= param_vsync_end;
                        r_state       <= ST_SYNC;
                    end
                end
                default: begin
                    if (w_h_wrap) begin
                        r_h_cnt <= '0;
                        r_v_cnt <= (r_v_cnt == r_vtotal) ? '0 : (r_v_cnt + V_WIDTH'(1));
                    end else begin
                        r_h_cnt <= r_h_cnt + H_WIDTH'(1);
                    end
                    if (w_fault) begin
                        r_underflow <= 1'b1;
                    end
                    if (w_frame_end) begin
                        r_underflow <= 1'b0;
                        if (!enable) begin
                            r_state <= ST_IDLE;
                        end else begin
                            r_htotal      <= param_htotal;
                            r_hdisp       <= param_hdisp;
                            r_hsync_start <= param_hsync_start;
                            r_hsync_end   <= param_hsync_end;
                            r_vtotal      <= param_vtotal;
                            r_vdisp       <= param_vdisp;
                            r_vsync_start <= param_vsync_start;
                            r_vsync_end   <= param_vsync_end;
                            if (r_state == ST_SYNC) begin
                                r_state <= w_sof_held ? ST_RUN : ST_SYNC;
                            end else begin
                                r_state <= r_underflow ? ST_SYNC : ST_RUN;
                            end
                        end
                    end
                end
            endcase
        end
    end

    assign busy          = (r_state != ST_IDLE);
    assign out_underflow = r_underflow;

    // Video outputs registered one cycle behind the counters; black unless locked
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            out_de    <= 1'b0;
            out_hsync <= ~SYNC_POL;
            out_vsync <= ~SYNC_POL;
            out_data  <= '0;
        end else if (r_state == ST_IDLE) begin
            out_de    <= 1'b0;
            out_hsync <= ~SYNC_POL;
            out_vsync <= ~SYNC_POL;
            out_data  <= '0;
        end else begin
            out_de    <= w_de;
            out_hsync <= w_hs_act ? SYNC_POL : ~SYNC_POL;
            out_vsync <= w_vs_act ? SYNC_POL : ~SYNC_POL;
            out_data  <= ((r_state == ST_RUN) && w_de && s_axi4s.tvalid) ? s_axi4s.tdata : '0;
        end
    end

`ifdef VOUT_AXI4S_TO_VIDEO_UNDERFLOW_CNT_EN
    logic [15:0] r_uf_count;

    // Saturating count of frames that ended with underflow or misalignment
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            r_uf_count <= '0;
        end else if ((r_state == ST_IDLE) && enable) begin
            r_uf_count <= '0;
        end else if ((r_state == ST_RUN) && w_frame_end && r_underflow &&
                     (r_uf_count != 16'hFFFF)) begin
            r_uf_count <= r_uf_count + 16'd1;
        end
    end

    assign status_underflow_count = r_uf_count;
`endif

endmodule

// File: tb/tb_vout_axi4s_to_video_core.sv
// tb/tb_vout_axi4s_to_video_core.sv - directed bench for vout_axi4s_to_video_core on a 9x5 raster
`timescale 1ns/1ps
module tb_vout_axi4s_to_video_core;

    localparam int UW = 2;
    localparam int DW = 24;
    localparam int HW = 12;
    localparam int VW = 12;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          enable = 1'b0;
    logic          busy;
    logic [HW-1:0] htotal = 12'd8, hdisp = 12'd4, hs_start = 12'd5, hs_end = 12'd7;
    logic [VW-1:0] vtotal = 12'd4, vdisp = 12'd3, vs_start = 12'd3, vs_end = 12'd4;
    logic          vs, hs, de, uf;
    logic [DW-1:0] data;
`ifdef VOUT_AXI4S_TO_VIDEO_UNDERFLOW_CNT_EN
    logic [15:0]   uf_cnt;
`endif

    vout_axi4s_to_video_core_if #(.USER_WIDTH(UW), .DATA_WIDTH(DW)) s_if ();

    always #5 clk = ~clk;

    vout_axi4s_to_video_core #(
        .AXI4S_USER_WIDTH(UW),
        .AXI4S_DATA_WIDTH(DW),
        .H_WIDTH(HW),
        .V_WIDTH(VW),
        .SYNC_POL(1'b0)
    ) dut (
        .aresetn(rst_n),
        .aclk(clk),
        .enable(enable),
        .busy(busy),
        .param_htotal(htotal),
        .param_hdisp(hdisp),
        .param_hsync_start(hs_start),
        .param_hsync_end(hs_end),
        .param_vtotal(vtotal),
        .param_vdisp(vdisp),
        .param_vsync_start(vs_start),
        .param_vsync_end(vs_end),
        .s_axi4s(s_if.slave),
        .out_vsync(vs),
        .out_hsync(hs),
        .out_de(de),
        .out_data(data),
        .out_underflow(uf)
`ifdef VOUT_AXI4S_TO_VIDEO_UNDERFLOW_CNT_EN
        ,
        .status_underflow_count(uf_cnt)
`endif
    );

    int n_checks = 0;
    int n_pass   = 0;
    int p        = 0;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
    endtask

    task automatic drive_src(input int pos, input int hole_pos, input bit bad_tlast);
        s_if.tvalid = (pos != hole_pos);
        s_if.tdata  = DW'(p + 1);
        s_if.tuser  = {(p == 11), (p == 0)};
        s_if.tlast  = bad_tlast ? ((p == 2) || ((p % 4 == 3) && (p != 3))) : (p % 4 == 3);
    endtask

    task automatic check_reset_outputs(input string name);
        chk({name, " busy"},   32'(busy), 32'd0);
        chk({name, " tready"}, 32'(s_if.tready), 32'd0);
        chk({name, " de"},     32'(de), 32'd0);
        chk({name, " data"},   32'(data), 32'd0);
        chk({name, " hsync"},  32'(hs), 32'd1);
        chk({name, " vsync"},  32'(vs), 32'd1);
        chk({name, " uf"},     32'(uf), 32'd0);
    endtask

    task automatic start_run();
        drive_src(0, -1, 1'b0);
        enable = 1'b1;
        @(posedge clk); #1;
    endtask

    // mode 0: black SYNC frame, 1: full image 1..12, 2: hole at pixel 1 of the first line
    task automatic run_frame(input string name, input int mode, input bit exp_uf,
                             input int hole_pos, input bit bad_tlast, input int drop_en_pos);
        for (int i = 0; i < 45; i++) begin
            int  h     = i % 9;
            int  v     = i / 9;
            bit  e_de  = (h < 4) && (v < 3);
            bit  acc;
            drive_src(i, hole_pos, bad_tlast);
            if (i == drop_en_pos) enable = 1'b0;
            @(negedge clk);
            if (mode == 0) chk($sformatf("%s p%0d tready", name, i), 32'(s_if.tready), 32'(p != 0));
            else           chk($sformatf("%s p%0d tready", name, i), 32'(s_if.tready), 32'(e_de));
            acc = s_if.tvalid && s_if.tready;
            @(posedge clk); #1;
            chk($sformatf("%s p%0d de", name, i),    32'(de), 32'(e_de));
            chk($sformatf("%s p%0d hsync", name, i), 32'(hs), (h == 5 || h == 6) ? 32'd0 : 32'd1);
            chk($sformatf("%s p%0d vsync", name, i), 32'(vs), (v == 3) ? 32'd0 : 32'd1);
            chk($sformatf("%s p%0d busy", name, i),  32'(busy),
                (drop_en_pos >= 0 && i == 44) ? 32'd0 : 32'd1);
            if (mode == 1)
                chk($sformatf("%s p%0d data", name, i), 32'(data), e_de ? 32'(v * 4 + h + 1) : 32'd0);
            else if (mode == 0 || !e_de)
                chk($sformatf("%s p%0d data", name, i), 32'(data), 32'd0);
            else if (i == 0)
                chk($sformatf("%s p%0d data", name, i), 32'(data), 32'd1);
            else if (i == 1)
                chk($sformatf("%s p%0d data", name, i), 32'(data), 32'd0);
            if (i == 40) chk($sformatf("%s uf", name), 32'(uf), 32'(exp_uf));
            if (acc) p = (p + 1) % 12;
        end
    endtask

    initial begin
        s_if.tvalid = 1'b0;
        s_if.tdata  = '0;
        s_if.tuser  = '0;
        s_if.tlast  = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check_reset_outputs("reset");
        rst_n = 1'b1;

        // locked source: black frame, then image
        p = 0;
        start_run();
        run_frame("f0_black", 0, 1'b0, -1, 1'b0, -1);
        run_frame("f1_img",   1, 1'b0, -1, 1'b0, -1);
        // missing second pixel of first line, resync, recover
        run_frame("f2_hole",  2, 1'b1,  1, 1'b0, -1);
        run_frame("f3_black", 0, 1'b0, -1, 1'b0, -1);
        // enable drops mid-frame: frame completes, then idle
        run_frame("f4_img",   1, 1'b0, -1, 1'b0, 10);
        for (int k = 0; k < 3; k++) begin
            drive_src(0, -1, 1'b0);
            @(posedge clk); #1;
            check_reset_outputs($sformatf("idle%0d", k));
        end
`ifdef VOUT_AXI4S_TO_VIDEO_UNDERFLOW_CNT_EN
        chk("uf_cnt before restart", 32'(uf_cnt), 32'd1);
`endif

        // restart with source mid-frame
        p = 5;
        start_run();
`ifdef VOUT_AXI4S_TO_VIDEO_UNDERFLOW_CNT_EN
        chk("uf_cnt cleared", 32'(uf_cnt), 32'd0);
`endif
        run_frame("g0_black", 0, 1'b0, -1, 1'b0, -1);
        run_frame("g1_img",   1, 1'b0, -1, 1'b0, -1);
        // tlast on pixel 3 of the first line
        run_frame("g2_tlast", 1, 1'b1, -1, 1'b1, -1);
        run_frame("g3_black", 0, 1'b0, -1, 1'b0, -1);
`ifdef VOUT_AXI4S_TO_VIDEO_UNDERFLOW_CNT_EN
        chk("uf_cnt after tlast", 32'(uf_cnt), 32'd1);
`endif
        run_frame("g4_img",   1, 1'b0, -1, 1'b0, -1);

        // asynchronous reset mid-line
        for (int i = 0; i < 3; i++) begin
            bit acc;
            drive_src(i, -1, 1'b0);
            @(negedge clk);
            acc = s_if.tvalid && s_if.tready;
            @(posedge clk); #1;
            if (i == 1) begin
                chk("pre_reset de",   32'(de), 32'd1);
                chk("pre_reset data", 32'(data), 32'd2);
            end
            if (acc) p = (p + 1) % 12;
        end
        #1 rst_n = 1'b0;
        #1;
        check_reset_outputs("async_reset");
        enable = 1'b0;
        repeat (2) @(posedge clk);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
